add_sub_unit: RTL and testbench

- Two-stage pipelined arithmetic block.
- Stage 1 adds operands `a` and `b` into `sum`; stage 2 subtracts operand `c` from that `sum` into `result`.
- It flags borrow and zero on the result.
- It is the shared datapath that couples the adder and subtractor through one operand bus, and it feeds downstream logic with valid-qualified `sum` and `result`.

---
 rtl/add_sub_unit.sv | 68 ++++++
 tb/tb_add_sub_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/add_sub_unit.sv
// Two-stage pipelined unsigned add-then-subtract datapath with borrow/zero flags.
// Optional build macro ADDSUB_SAT_EN: clamp result to 0 on borrow instead of wrapping.
module add_sub_unit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH:0]   sum,
  output logic             sum_valid,
  output logic [WIDTH:0]   result,
  output logic             borrow,
  output logic             zero,
  output logic             res_valid
);

  logic [WIDTH-1:0] c_d;
  logic [WIDTH:0]   diff;
  logic [WIDTH:0]   result_nx;
  logic             borrow_nx;
  logic             zero_nx;

  // c travels with its a/b so a later change of c cannot disturb a pending result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      c_d       <= '0;
      sum_valid <= 1'b0;
    end else begin
      sum_valid <= in_valid;
      if (in_valid) begin
        sum <= {1'b0, a} + {1'b0, b};
        c_d <= c;
      end
    end
  end

  always_comb begin
    diff      = sum - {1'b0, c_d};
    borrow_nx = ({1'b0, c_d} > sum);
`ifdef ADDSUB_SAT_EN
    result_nx = borrow_nx ? '0 : diff;
`else
    result_nx = diff;
`endif
    zero_nx   = (result_nx == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result    <= '0;
      borrow    <= 1'b0;
      zero      <= 1'b0;
      res_valid <= 1'b0;
    end else begin
      res_valid <= sum_valid;
      if (sum_valid) begin
        result <= result_nx;
        borrow <= borrow_nx;
        zero   <= zero_nx;
      end
    end
  end

endmodule

// File: tb/tb_add_sub_unit.sv
// Self-checking bench for add_sub_unit (WIDTH=4), directed plus randomized streams
// checked against an integer-arithmetic reference model.
module tb_add_sub_unit;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [W-1:0] c = '0;
  logic [W:0]   sum;
  logic         sum_valid;
  logic [W:0]   result;
  logic         borrow;
  logic         zero;
  logic         res_valid;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int res;
    bit brw;
    bit zr;
  } exp_t;

  add_sub_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a), .b(b), .c(c),
    .sum(sum), .sum_valid(sum_valid),
    .result(result), .borrow(borrow), .zero(zero), .res_valid(res_valid)
  );

  always #5 clk = ~clk;

  function automatic exp_t ref_model(int av, int bv, int cv);
    exp_t e;
    int s;
    int d;
    s = av + bv;
    d = s - cv;
    e.brw = (cv > s);
    if (d < 0) begin
`ifdef ADDSUB_SAT_EN
      d = 0;
`else
      d = d + (1 << (W + 1));
`endif
    end
    e.res = d;
    e.zr  = (d == 0);
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    #12;
    n_cmp++;
    if ({sum, sum_valid, result, borrow, zero, res_valid} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got sum=%0d sv=%0b res=%0d brw=%0b z=%0b rv=%0b, want all 0",
               sum, sum_valid, result, borrow, zero, res_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_directed();
    int ta[4] = '{3, 15, 1, 1};
    int tb_[4] = '{10, 15, 1, 0};
    int tc[4] = '{2, 0, 2, 3};
    int esum[4] = '{13, 30, 2, 1};
    int eres[4];
    bit ebrw[4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    bit ez[4];
    eres[0] = 11; eres[1] = 30; eres[2] = 0;
    ez[0] = 1'b0; ez[1] = 1'b0; ez[2] = 1'b1;
`ifdef ADDSUB_SAT_EN
    eres[3] = 0;  ez[3] = 1'b1;
`else
    eres[3] = 30; ez[3] = 1'b0;
`endif
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      a = W'(ta[i]); b = W'(tb_[i]); c = W'(tc[i]);
      step();
      n_cmp++;
      if (sum !== (W+1)'(esum[i]) || sum_valid !== 1'b1 || res_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL dir%0d_stage1: got sum=%0d sv=%0b rv=%0b, want sum=%0d sv=1 rv=0",
                 i, sum, sum_valid, res_valid, esum[i]);
      end
      in_valid = 1'b0;
      a = W'($urandom); b = W'($urandom); c = W'($urandom);
      step();
      n_cmp++;
      if (result !== (W+1)'(eres[i]) || borrow !== ebrw[i] || zero !== ez[i] ||
          res_valid !== 1'b1 || sum_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL dir%0d_stage2: got res=%0d brw=%0b z=%0b rv=%0b sv=%0b, want res=%0d brw=%0b z=%0b rv=1 sv=0",
                 i, result, borrow, zero, res_valid, sum_valid, eres[i], ebrw[i], ez[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int ta[3] = '{2, 7, 4};
    int tb_[3] = '{3, 9, 4};
    int tc[3] = '{1, 15, 9};
    exp_t e;
    for (int t = 0; t < 5; t++) begin
      if (t < 3) begin
        in_valid = 1'b1;
        a = W'(ta[t]); b = W'(tb_[t]); c = W'(tc[t]);
      end else begin
        in_valid = 1'b0;
        c = W'($urandom);
      end
      step();
      if (t < 3) begin
        n_cmp++;
        if (sum_valid !== 1'b1 || sum !== (W+1)'(ta[t] + tb_[t])) begin
          n_bad++;
          $display("FAIL b2b_sum%0d: got sum=%0d sv=%0b, want sum=%0d sv=1",
                   t, sum, sum_valid, ta[t] + tb_[t]);
        end
      end
      if (t >= 1 && t <= 3) begin
        e = ref_model(ta[t-1], tb_[t-1], tc[t-1]);
        n_cmp++;
        if (res_valid !== 1'b1 || result !== (W+1)'(e.res) || borrow !== e.brw || zero !== e.zr) begin
          n_bad++;
          $display("FAIL b2b_res%0d: got res=%0d brw=%0b z=%0b rv=%0b, want res=%0d brw=%0b z=%0b rv=1",
                   t - 1, result, borrow, zero, res_valid, e.res, e.brw, e.zr);
        end
      end
      if (t == 4) begin
        n_cmp++;
        if (res_valid !== 1'b0 || sum_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL b2b_drain: got rv=%0b sv=%0b, want 0 0", res_valid, sum_valid);
        end
      end
    end
  endtask

  task automatic test_idle_hold();
    exp_t e;
    in_valid = 1'b1;
    a = 4'd9; b = 4'd6; c = 4'd5;
    step();
    in_valid = 1'b0;
    step();
    e = ref_model(9, 6, 5);
    for (int t = 0; t < 4; t++) begin
      a = W'($urandom); b = W'($urandom); c = W'($urandom);
      step();
      n_cmp++;
      if (sum !== 5'd15 || result !== (W+1)'(e.res) || borrow !== e.brw || zero !== e.zr ||
          sum_valid !== 1'b0 || res_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL idle_hold%0d: got sum=%0d res=%0d brw=%0b z=%0b sv=%0b rv=%0b, want sum=15 res=%0d brw=%0b z=%0b sv=0 rv=0",
                 t, sum, result, borrow, zero, sum_valid, res_valid, e.res, e.brw, e.zr);
      end
    end
  endtask

  task automatic test_midstream_reset();
    in_valid = 1'b1;
    a = 4'd5; b = 4'd5; c = 4'd1;
    step();
    step();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({sum, sum_valid, result, borrow, zero, res_valid} !== '0) begin
      n_bad++;
      $display("FAIL midreset_clear: got sum=%0d sv=%0b res=%0d brw=%0b z=%0b rv=%0b, want all 0",
               sum, sum_valid, result, borrow, zero, res_valid);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int t = 0; t < 2; t++) begin
      step();
      n_cmp++;
      if (res_valid !== 1'b0 || sum_valid !== 1'b0 || result !== '0 || sum !== '0) begin
        n_bad++;
        $display("FAIL midreset_flush%0d: got rv=%0b sv=%0b res=%0d sum=%0d, want 0 0 0 0",
                 t, res_valid, sum_valid, result, sum);
      end
    end
  endtask

  task automatic test_random();
    localparam int N = 200;
    bit vin[N];
    int va[N];
    int vb[N];
    int vc[N];
    int last_s;
    int last_r;
    exp_t e;
    last_s = -1;
    for (int t = 0; t < N; t++) begin
      vin[t] = ($urandom_range(0, 3) != 0);
      va[t] = int'($urandom_range(0, (1 << W) - 1));
      vb[t] = int'($urandom_range(0, (1 << W) - 1));
      vc[t] = int'($urandom_range(0, (1 << (W - 1)) + (1 << W) - 1)) % (1 << W);
      in_valid = vin[t];
      a = W'(va[t]); b = W'(vb[t]); c = W'(vc[t]);
      step();
      last_r = last_s;
      if (vin[t]) last_s = t;
      n_cmp++;
      if (sum_valid !== vin[t] || res_valid !== ((t > 0) ? vin[t-1] : 1'b0)) begin
        n_bad++;
        $display("FAIL rand_valid@%0d: got sv=%0b rv=%0b, want sv=%0b rv=%0b",
                 t, sum_valid, res_valid, vin[t], (t > 0) ? vin[t-1] : 1'b0);
      end
      if (last_s >= 0) begin
        n_cmp++;
        if (sum !== (W+1)'(va[last_s] + vb[last_s])) begin
          n_bad++;
          $display("FAIL rand_sum@%0d: got %0d, want %0d", t, sum, va[last_s] + vb[last_s]);
        end
      end
      if (last_r >= 0) begin
        e = ref_model(va[last_r], vb[last_r], vc[last_r]);
        n_cmp++;
        if (result !== (W+1)'(e.res) || borrow !== e.brw || zero !== e.zr) begin
          n_bad++;
          $display("FAIL rand_res@%0d: got res=%0d brw=%0b z=%0b, want res=%0d brw=%0b z=%0b",
                   t, result, borrow, zero, e.res, e.brw, e.zr);
        end
      end
    end
    in_valid = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_idle_hold();
    test_random();
    test_midstream_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
